// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver: synchronises the line, locks the sample phase to the
// start edge, majority-votes each bit at mid-bit and reports one byte or error per frame.
module uart_rx_os #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_Rx_Serial,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Rx_Valid,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Busy
);

  localparam int unsigned DIV   = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int unsigned TW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW    = $clog2(OVERSAMPLE);
  localparam int unsigned BW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  // Sample k is the rx_s value at the start of tick period k, so the three votes are
  // captured on the ticks that close periods k-1 for k = OS/2-1, OS/2, OS/2+1.
  localparam int unsigned S_A   = OVERSAMPLE / 2 - 2;
  localparam int unsigned S_B   = OVERSAMPLE / 2 - 1;
  localparam int unsigned S_C   = OVERSAMPLE / 2;
  localparam int unsigned S_END = OVERSAMPLE - 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PAR       = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0]           fill_q;
  logic                 armed_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [SW-1:0]        samp_q;
  logic [1:0]           votes_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q;

  logic tick_c, start_edge_c, at_mid_c, at_end_c, bit_c, last_bit_c;
  logic valid_c, frame_err_c, parity_err_c, busy_c;

  // Shared decode of the tick/sample position within the current bit.
  always_comb begin
    tick_c       = (tick_cnt_q == TW'(DIV - 1));
    start_edge_c = (state_q == IDLE) && armed_q && rx_prev_q && !rx_s_q;
    at_mid_c     = tick_c && (samp_q == SW'(S_C));
    at_end_c     = tick_c && (samp_q == SW'(S_END));
    bit_c        = (votes_q[0] & votes_q[1]) | (votes_q[0] & rx_s_q) | (votes_q[1] & rx_s_q);
    last_bit_c   = (bit_cnt_q == BW'(DATA_BITS - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_edge_c) state_d = START;
      end
      START: begin
        if (at_mid_c && bit_c) state_d = IDLE;
        else if (at_end_c)     state_d = DATA;
      end
      DATA: begin
        if (at_end_c && last_bit_c) state_d = (PARITY != 0) ? PAR : STOP;
      end
      PAR: begin
        if (at_end_c) state_d = STOP;
      end
      STOP: begin
        if (at_mid_c) state_d = bit_c ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; the strobes and busy are registered below.
  always_comb begin
    valid_c      = 1'b0;
    frame_err_c  = 1'b0;
    parity_err_c = 1'b0;
    if ((state_q == STOP) && at_mid_c) begin
      if (!bit_c)        frame_err_c  = 1'b1;
      else if (par_err_q) parity_err_c = 1'b1;
      else               valid_c      = 1'b1;
    end
    busy_c = (state_d == START) || (state_d == DATA) || (state_d == PAR) || (state_d == STOP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      fill_q       <= 2'b00;
      armed_q      <= 1'b0;
      tick_cnt_q   <= '0;
      samp_q       <= '0;
      votes_q      <= 2'b11;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      o_Rx_Data    <= '0;
      o_Rx_Valid   <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Busy       <= 1'b0;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      // A line held low through reset must be seen high before a fall counts as a start.
      fill_q    <= {fill_q[0], 1'b1};
      if (fill_q[1] && rx_s_q) armed_q <= 1'b1;

      if (start_edge_c || tick_c) tick_cnt_q <= '0;
      else                        tick_cnt_q <= tick_cnt_q + TW'(1);

      if (start_edge_c)  samp_q <= '0;
      else if (at_end_c) samp_q <= '0;
      else if (tick_c)   samp_q <= samp_q + SW'(1);

      if (tick_c && (samp_q == SW'(S_A))) votes_q[0] <= rx_s_q;
      if (tick_c && (samp_q == SW'(S_B))) votes_q[1] <= rx_s_q;

      if (start_edge_c)                       bit_cnt_q <= '0;
      else if ((state_q == DATA) && at_end_c) bit_cnt_q <= bit_cnt_q + BW'(1);

      if ((state_q == DATA) && at_mid_c) shift_q <= {bit_c, shift_q[DATA_BITS-1:1]};

      if (start_edge_c) begin
        par_err_q <= 1'b0;
      end else if ((state_q == PAR) && at_mid_c) begin
        par_err_q <= ((^shift_q) ^ bit_c) != (PARITY == 2);
      end

      o_Rx_Valid   <= valid_c;
      o_Frame_Err  <= frame_err_c;
      o_Parity_Err <= parity_err_c;
      o_Busy       <= busy_c;
      if (valid_c) o_Rx_Data <= shift_q;
    end
  end

endmodule
